fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Downstream consumer of the byte fifo. Drains bytes whenever the fifo reports non-empty and serialises each one onto an asynchronous serial line: 8N1, LSB first, idle high.
- Sits between the fifo read port and the board TX pin.
- Owns the fifo read strobe and matches the fifo's registered-read timing: rdata is valid the cycle after read is asserted.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit period. Legal range is ≥2, ≤65535.
- CNT_W, 16: width of the bit-period counter and of tx_count.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset; sampled on posedge clk
- fifo_emptyB  input  1  from fifo; 1 = fifo holds ≥1 byte
- fifo_rdata  input  8  from fifo; valid the cycle after fifo_read=1
- fifo_read  output  1  to fifo; one-cycle pop strobe
- tx_enable  input  1  1 = may start new frames; 0 = finish current frame, then hold idle
- txd  output  1  serial data; idle 1
- busy  output  1  1 from FETCH through end of STOP
- tx_count  output  CNT_W  frames completed since reset; wraps

Behaviour:
- Reset (reset=0 at a posedge):
  - state←IDLE, txd←1, fifo_read←0, busy←0, tx_count←0, bit counter←0, shift reg←0.
  - Reset has priority over all other activity.
  - Reset mid-frame aborts the frame: txd is 1 from the next cycle, and the popped byte is discarded (not re-read).
- All outputs are registered (Moore): they change only on posedge clk.
- IDLE: txd=1, busy=0, fifo_read=0. Go to FETCH when fifo_emptyB=1 and tx_enable=1.
- FETCH (1 cycle): fifo_read=1, busy=1. Always go to LOAD.
- LOAD (1 cycle): fifo_read=0. At the end of this cycle, shift reg←fifo_rdata, period counter←0, bit index←0. Go to START.
- START: txd=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
- DATA: txd=shift[0]. After CLKS_PER_BIT cycles, shift right and increment the bit index. After the 8th bit completes, go to STOP.
- STOP: txd=1 for exactly CLKS_PER_BIT cycles. On the last cycle, tx_count←tx_count+1 (mod 2^CNT_W) and go to IDLE.
- Frame timing:
  - Each frame occupies 10*CLKS_PER_BIT cycles of txd.
  - The minimum gap between the end of one stop bit and the next start bit is 3 cycles (IDLE, FETCH, LOAD), all with txd=1.
- Exactly one fifo_read pulse per frame, never asserted in consecutive cycles. Because the fifo's emptyB lags the pop by one edge, fifo_emptyB is sampled only in IDLE.
- tx_enable:
  - Sampled only in IDLE.
  - Deasserting it mid-frame does not truncate the frame; the block returns to IDLE and stays there while tx_enable=0.
- Empty fifo: the block stays in IDLE indefinitely and never asserts fifo_read.
- fifo_rdata is ignored in every state except LOAD.
- Counters:
  - Period counter counts 0..CLKS_PER_BIT-1 and resets at each bit boundary.
  - tx_count wraps FFFF→0000 with no saturation.

Test Plan:
- CLKS_PER_BIT=4; fifo preloaded with 0x41; tx_enable=1.
  - fifo_read high for exactly 1 cycle; start bit begins 2 cycles after the read pulse.
  - txd bit sequence 0,1,0,0,0,0,0,1,0,1, each bit held 4 cycles.
  - busy high for 42 cycles; tx_count=1; then idle with txd=1.
- Three bytes 0x00, 0xFF, 0x55 preloaded.
  - Three frames with correct LSB-first bits.
  - Exactly 3 idle-high cycles between each stop bit and the following start bit.
  - 3 read pulses; tx_count=3; no 4th read once fifo_emptyB=0.
- Empty fifo for 200 cycles → fifo_read never 1, txd constant 1, busy=0.
- tx_enable dropped at bit 3 of a frame with 2 bytes queued.
  - Current frame completes intact; tx_count=1; no further read while tx_enable=0.
  - Re-asserting tx_enable → second frame starts within 3 cycles.
- reset=0 for 1 cycle during DATA bit 5.
  - Next cycle: txd=1, busy=0, tx_count=0, state IDLE.
  - With fifo non-empty after release, the next byte is fetched and sent correctly from its start bit.
- tx_count forced/preloaded near wrap (0xFFFF) and one frame sent → tx_count=0x0000.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// Read-port bundle between the byte fifo and the UART transmitter that drains it.
// The transmitter (master) owns the pop strobe; the fifo (slave) supplies status and data.
interface fifo_uart_tx_if;
  logic       fifo_emptyB;
  logic [7:0] fifo_rdata;
  logic       fifo_read;

  modport master (input fifo_emptyB, input fifo_rdata, output fifo_read);
  modport slave  (output fifo_emptyB, output fifo_rdata, input fifo_read);
endinterface

// File: rtl/fifo_uart_tx.sv
// Fifo-draining 8N1 UART transmitter: pops one byte per frame and shifts it out LSB first.
// Every output is a register; the fifo data is captured the cycle after the pop strobe.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  fifo_uart_tx_if.master   fifo,
  input  logic             tx_enable,
  output logic             txd,
  output logic             busy,
  output logic [CNT_W-1:0] tx_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             txd_r;
  logic             busy_r;
  logic             fifo_read_r;
  logic [CNT_W-1:0] tx_count_r;
  logic             period_done_s;

  assign period_done_s  = (cnt_r == LAST_CNT);
  assign txd            = txd_r;
  assign busy           = busy_r;
  assign tx_count       = tx_count_r;
  assign fifo.fifo_read = fifo_read_r;

  // Frame sequencer: fetch, load, then start/data/stop bit periods.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      txd_r       <= 1'b1;
      fifo_read_r <= 1'b0;
      busy_r      <= 1'b0;
      tx_count_r  <= CNT_ZERO;
      cnt_r       <= CNT_ZERO;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          txd_r <= 1'b1;
          // emptyB lags a pop by one edge, so it is only trusted here
          if (fifo.fifo_emptyB && tx_enable) begin
            state_r     <= ST_FETCH;
            fifo_read_r <= 1'b1;
            busy_r      <= 1'b1;
          end else begin
            fifo_read_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        ST_FETCH: begin
          fifo_read_r <= 1'b0;
          state_r     <= ST_LOAD;
        end
        ST_LOAD: begin
          shift_r   <= fifo.fifo_rdata;
          cnt_r     <= CNT_ZERO;
          bit_idx_r <= 3'd0;
          txd_r     <= 1'b0;
          state_r   <= ST_START;
        end
        ST_START: begin
          if (period_done_s) begin
            cnt_r   <= CNT_ZERO;
            txd_r   <= shift_r[0];
            state_r <= ST_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (period_done_s) begin
            cnt_r   <= CNT_ZERO;
            shift_r <= {1'b0, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              txd_r   <= 1'b1;
              state_r <= ST_STOP;
            end else begin
              txd_r     <= shift_r[1];
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (period_done_s) begin
            cnt_r      <= CNT_ZERO;
            tx_count_r <= tx_count_r + CNT_ONE;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          txd_r       <= 1'b1;
          fifo_read_r <= 1'b0;
          busy_r      <= 1'b0;
          cnt_r       <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a queue-based fifo model feeds random bytes, and a
// negedge monitor decodes the serial line and pops expected bytes from the scoreboard.
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        tx_enable = 1'b0;
  logic        txd;
  logic        busy;
  logic [15:0] tx_count;
  logic        tx_en_w   = 1'b0;
  logic        txd_w;
  logic        busy_w;
  logic [3:0]  tx_count_w;

  fifo_uart_tx_if fifo_bus ();
  fifo_uart_tx_if w_bus ();

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .fifo(fifo_bus), .tx_enable(tx_enable),
    .txd(txd), .busy(busy), .tx_count(tx_count)
  );

  // Narrow counter instance so wrap-around is reachable in a few frames
  fifo_uart_tx #(.CLKS_PER_BIT(2), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .fifo(w_bus), .tx_enable(tx_en_w),
    .txd(txd_w), .busy(busy_w), .tx_count(tx_count_w)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  int cyc = 0, mon_cyc = 0, gap_cnt = 0, read_cnt = 0, read_cyc = 0, start_cyc = 0;
  int frames_done = 0, busy_run = 0, pos = 0, off = 0, w_frames = 0;
  bit mon_in = 1'b0, frame_ok = 1'b0, have_prev = 1'b0, busy_abort = 1'b0;
  bit busy_ever = 1'b0, prev_read = 1'b0, expect_tight = 1'b0, w_busy_prev = 1'b0;
  logic [7:0] bits = 8'h00;
  logic [7:0] exp_b;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    tx_enable    = 1'b0;
    tx_en_w      = 1'b0;
    expect_tight = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_frames(input int n, input int bound);
    int k = 0;
    while (frames_done < n && k < bound) begin
      tick();
      k++;
    end
    check("frame_timeout", longint'(frames_done >= n), 1);
  endtask

  task automatic wait_reads(input int n, input int bound);
    int k = 0;
    while (read_cnt < n && k < bound) begin
      tick();
      k++;
    end
    check("read_timeout", longint'(read_cnt >= n), 1);
  endtask

  task automatic wait_w(input int n, input int bound);
    int k = 0;
    while (w_frames < n && k < bound) begin
      tick();
      k++;
    end
    check("w_frame_timeout", longint'(w_frames >= n), 1);
  endtask

  // Fifo model: registered read data and registered non-empty flag; garbage when not popping
  always @(posedge clk) begin
    if (fifo_bus.fifo_read === 1'b1) begin
      if (fifo_q.size() == 0) check("read_on_empty", 1, 0);
      else fifo_bus.fifo_rdata <= fifo_q.pop_front();
    end else begin
      fifo_bus.fifo_rdata <= 8'($urandom);
    end
    fifo_bus.fifo_emptyB <= (fifo_q.size() != 0);
  end

  // Line monitor: decodes 8N1 frames, checks strobe spacing, busy length and gaps
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      mon_in      = 1'b0;
      have_prev   = 1'b0;
      gap_cnt     = 0;
      read_cnt    = 0;
      frames_done = 0;
      prev_read   = 1'b0;
      busy_ever   = 1'b0;
      if (busy_run > 0) busy_abort = 1'b1;
    end else begin
      if (fifo_bus.fifo_read === 1'b1) begin
        if (prev_read) check("read_back_to_back", 1, 0);
        else begin
          read_cnt++;
          read_cyc = cyc;
        end
      end
      prev_read = (fifo_bus.fifo_read === 1'b1);

      if (busy === 1'b1) begin
        busy_run++;
        busy_ever = 1'b1;
      end else begin
        if (busy_run > 0 && !busy_abort) begin
          check("busy_len", busy_run, FRAME + 2);
          check("tx_count_at_end", tx_count, frames_done);
        end
        busy_run   = 0;
        busy_abort = 1'b0;
        check("idle_txd", txd, 1);
      end

      if (!mon_in) begin
        if (txd === 1'b0) begin
          if (have_prev && gap_cnt < 3) check("gap_min", gap_cnt, 3);
          if (have_prev && expect_tight) check("gap_tight", gap_cnt, 3);
          check("read_to_start", cyc - read_cyc, 2);
          start_cyc = cyc;
          mon_in    = 1'b1;
          mon_cyc   = 1;
          frame_ok  = 1'b1;
          bits      = 8'h00;
        end else begin
          gap_cnt++;
        end
      end else begin
        pos = mon_cyc / CPB;
        off = mon_cyc % CPB;
        if (pos == 0) begin
          if (txd !== 1'b0) frame_ok = 1'b0;
        end else if (pos <= 8) begin
          if (off == 0) bits[pos-1] = txd;
          else if (txd !== bits[pos-1]) frame_ok = 1'b0;
        end else begin
          if (txd !== 1'b1) frame_ok = 1'b0;
        end
        if (mon_cyc == FRAME - 1) begin
          frames_done++;
          check("framing", frame_ok, 1);
          if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
          else begin
            exp_b = exp_q.pop_front();
            check("data_byte", bits, exp_b);
          end
          have_prev = 1'b1;
          gap_cnt   = 0;
          mon_in    = 1'b0;
        end else begin
          mon_cyc++;
        end
      end
    end
  end

  // Frame counter for the narrow instance, one per busy falling edge
  always @(negedge clk) begin
    if (!reset) begin
      w_frames    = 0;
      w_busy_prev = 1'b0;
    end else begin
      if (w_busy_prev && busy_w === 1'b0) w_frames++;
      w_busy_prev = (busy_w === 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cyc;
    w_bus.fifo_emptyB = 1'b1;
    w_bus.fifo_rdata  = 8'h3C;
    reset = 1'b0;
    repeat (3) tick();
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_read", fifo_bus.fifo_read, 0);
    check("rst_count", tx_count, 0);
    check("rst_count_w", tx_count_w, 0);
    reset = 1'b1;
    tick();

    // Single 0x41 frame
    do_reset();
    push(8'h41);
    tx_enable = 1'b1;
    wait_frames(1, 200);
    repeat (5) tick();
    check("t1_tx_count", tx_count, 1);
    check("t1_reads", read_cnt, 1);
    check("t1_txd_idle", txd, 1);
    check("t1_busy", busy, 0);

    // Back-to-back frames with minimum gap
    do_reset();
    expect_tight = 1'b1;
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    tx_enable = 1'b1;
    wait_frames(3, 400);
    repeat (20) tick();
    check("t2_tx_count", tx_count, 3);
    check("t2_reads", read_cnt, 3);
    check("t2_scoreboard_empty", exp_q.size(), 0);
    expect_tight = 1'b0;

    // Random bytes pushed at random intervals
    do_reset();
    tx_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(8'($urandom));
      repeat ($urandom_range(0, 60)) tick();
    end
    wait_frames(8, 2000);
    repeat (5) tick();
    check("t3_tx_count", tx_count, 8);
    check("t3_reads", read_cnt, 8);
    check("t3_scoreboard_empty", exp_q.size(), 0);

    // Empty fifo: nothing happens
    do_reset();
    tx_enable = 1'b1;
    repeat (200) tick();
    check("t4_reads", read_cnt, 0);
    check("t4_busy_ever", busy_ever, 0);
    check("t4_frames", frames_done, 0);
    check("t4_txd", txd, 1);

    // tx_enable dropped during data bit 3
    do_reset();
    push(8'($urandom));
    push(8'($urandom));
    tx_enable = 1'b1;
    wait_reads(1, 50);
    repeat (18) tick();
    tx_enable = 1'b0;
    wait_frames(1, 200);
    repeat (30) tick();
    check("t5_tx_count", tx_count, 1);
    check("t5_reads", read_cnt, 1);
    check("t5_pending", exp_q.size(), 1);
    tx_enable = 1'b1;
    en_cyc = cyc + 1;
    wait_frames(2, 200);
    check("t5_reenable_latency", longint'(start_cyc - en_cyc <= 3), 1);
    check("t5_tx_count2", tx_count, 2);

    // One-cycle reset during data bit 5
    do_reset();
    push(8'($urandom));
    push(8'($urandom));
    tx_enable = 1'b1;
    wait_reads(1, 50);
    repeat (26) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t6_txd", txd, 1);
    check("t6_busy", busy, 0);
    check("t6_count", tx_count, 0);
    void'(exp_q.pop_front());
    wait_frames(1, 200);
    repeat (5) tick();
    check("t6_tx_count", tx_count, 1);
    check("t6_reads", read_cnt, 1);
    check("t6_scoreboard_empty", exp_q.size(), 0);
    check("t6_fifo_drained", fifo_q.size(), 0);

    // Counter wrap on the 4-bit instance
    do_reset();
    tx_en_w = 1'b1;
    wait_w(15, 600);
    check("w_count_15", tx_count_w, w_frames % 16);
    wait_w(16, 100);
    check("w_count_wrap", tx_count_w, w_frames % 16);
    tx_en_w = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
